// File: rtl/ml_kem_sample_ntt.sv
// Rejection sampler for ML-KEM SampleNTT: parses 3-byte groups from the
// SHAKE128 squeeze stream into 12-bit candidates and keeps those below Q.
module ml_kem_sample_ntt #(
  parameter int N = 256,
  parameter int Q = 3329
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_i,
  input  logic [63:0]         din_i,
  input  logic                din_valid_i,
  output logic                din_ready_o,
  output logic [N-1:0][11:0]  poly_o,
  output logic [8:0]          cnt_o,
  output logic                done_o
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam logic [11:0] LP_Q = 12'(Q);
  localparam logic [8:0]  LP_N = 9'(N);

  state_t              r_state;
  state_t              w_state_next;
  logic [79:0]         r_buf;
  logic [3:0]          r_fill;
  logic [8:0]          r_cnt;
  logic [N-1:0][11:0]  r_poly;

  logic                w_ready;
  logic                w_accept;
  logic                w_consume;
  logic [11:0]         w_d1;
  logic [11:0]         w_d2;
  logic                w_keep1;
  logic                w_keep2;
  logic [8:0]          w_cnt_mid;
  logic [8:0]          w_cnt_next;
  logic [3:0]          w_fill_after;
  logic [3:0]          w_fill_next;
  logic [79:0]         w_buf_shift;
  logic [79:0]         w_buf_next;

  // Byte 0 of r_buf is the oldest; bytes at or above r_fill are always zero,
  // so appending a word is a plain OR at the post-consume fill position.
  assign w_ready      = (r_state == RUN) && (r_fill <= 4'd5);
  assign w_accept     = din_valid_i && w_ready && !start_i;
  assign w_consume    = (r_state == RUN) && (r_fill >= 4'd3) && !start_i;
  assign w_d1         = {r_buf[11:8], r_buf[7:0]};
  assign w_d2         = {r_buf[23:16], r_buf[15:12]};
  assign w_keep1      = w_consume && (w_d1 < LP_Q);
  assign w_cnt_mid    = r_cnt + {8'd0, w_keep1};
  assign w_keep2      = w_consume && (w_d2 < LP_Q) && (w_cnt_mid < LP_N);
  assign w_cnt_next   = w_cnt_mid + {8'd0, w_keep2};
  assign w_fill_after = w_consume ? (r_fill - 4'd3) : r_fill;
  assign w_fill_next  = w_fill_after + (w_accept ? 4'd8 : 4'd0);
  assign w_buf_shift  = w_consume ? (r_buf >> 24) : r_buf;
  assign w_buf_next   = w_buf_shift |
                        (w_accept ? ({16'd0, din_i} << {w_fill_after, 3'b000}) : 80'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (start_i) begin
      w_state_next = RUN;
    end else if ((r_state == RUN) && (w_cnt_next == LP_N)) begin
      w_state_next = DONE;
    end
  end

  // Restart clears buffer and count but leaves the polynomial to be overwritten.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf  <= '0;
      r_fill <= '0;
      r_cnt  <= '0;
      r_poly <= '0;
    end else begin
      if (start_i) begin
        r_buf  <= '0;
        r_fill <= '0;
        r_cnt  <= '0;
      end else if (r_state == RUN) begin
        r_buf  <= w_buf_next;
        r_fill <= w_fill_next;
        r_cnt  <= w_cnt_next;
      end
      if (w_keep1) begin
        r_poly[r_cnt[7:0]] <= w_d1;
      end
      if (w_keep2) begin
        r_poly[w_cnt_mid[7:0]] <= w_d2;
      end
    end
  end

  assign din_ready_o = w_ready;
  assign poly_o      = r_poly;
  assign cnt_o       = r_cnt;
  assign done_o      = (r_state == DONE);

endmodule

// File: tb/tb_ml_kem_sample_ntt.sv
// Self-checking bench for ml_kem_sample_ntt: directed parse/rejection/boundary
// cases plus randomized streams compared against a byte-queue reference model.
module tb_ml_kem_sample_ntt;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                start_i;
  logic [63:0]         din_i;
  logic                din_valid_i;
  logic                din_ready_o;
  logic [255:0][11:0]  poly_o;
  logic [8:0]          cnt_o;
  logic                done_o;

  int         tests = 0;
  int         fails = 0;
  logic [7:0] mq[$];
  int         mPoly[256];
  int         mCnt;
  bit         mRun;
  bit         mDone;
  int         dutAccepts;
  int         doneRises;
  logic       prevDone;

  ml_kem_sample_ntt #(.N(256), .Q(3329)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start_i),
    .din_i       (din_i),
    .din_valid_i (din_valid_i),
    .din_ready_o (din_ready_o),
    .poly_o      (poly_o),
    .cnt_o       (cnt_o),
    .done_o      (done_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic bit modelReady();
    return mRun && !mDone && (mq.size() <= 5);
  endfunction

  task automatic modelReset();
    mRun  = 1'b0;
    mDone = 1'b0;
    mq.delete();
    mCnt  = 0;
    foreach (mPoly[i]) mPoly[i] = 0;
  endtask

  // Reference: a byte FIFO drained three bytes per cycle, coefficients kept below q.
  task automatic modelEdge(input bit s, input bit v, input logic [63:0] d, output bit took);
    int b0, b1, b2, d1, d2;
    bit rdy;
    took = 1'b0;
    if (s) begin
      mRun  = 1'b1;
      mDone = 1'b0;
      mq.delete();
      mCnt  = 0;
    end else if (mRun && !mDone) begin
      rdy = (mq.size() <= 5);
      if (mq.size() >= 3) begin
        b0 = int'(mq.pop_front());
        b1 = int'(mq.pop_front());
        b2 = int'(mq.pop_front());
        d1 = b0 + 256 * (b1 % 16);
        d2 = (b1 / 16) + 16 * b2;
        if (d1 < 3329) begin
          mPoly[mCnt] = d1;
          mCnt++;
        end
        if ((d2 < 3329) && (mCnt < 256)) begin
          mPoly[mCnt] = d2;
          mCnt++;
        end
      end
      if (v && rdy) begin
        for (int k = 0; k < 8; k++) mq.push_back(d[8*k +: 8]);
        took = 1'b1;
      end
      if (mCnt == 256) mDone = 1'b1;
    end
  endtask

  task automatic checkOutput();
    chk("cnt", cnt_o, mCnt);
    chk("done", done_o, mDone);
  endtask

  task automatic checkPoly(input string tag);
    for (int i = 0; i < 256; i++) chk($sformatf("%s[%0d]", tag, i), poly_o[i], mPoly[i]);
  endtask

  task automatic applyStimulus(input bit s, input bit v, input logic [63:0] d, output bit took);
    start_i     = s;
    din_valid_i = v;
    din_i       = d;
    chk("ready", din_ready_o, modelReady());
    if (v && (din_ready_o === 1'b1)) dutAccepts++;
    @(posedge clk);
    modelEdge(s, v, d, took);
    #1;
    if ((done_o === 1'b1) && (prevDone !== 1'b1)) doneRises++;
    prevDone = done_o;
    checkOutput();
  endtask

  initial begin
    bit          took;
    logic [63:0] w;
    logic [7:0]  bytes[$];
    logic [63:0] words[$];
    logic [11:0] c1, c2;
    int          n, idx;

    rst_n       = 1'b0;
    start_i     = 1'b0;
    din_valid_i = 1'b0;
    din_i       = '0;
    prevDone    = 1'b0;
    dutAccepts  = 0;
    doneRises   = 0;
    modelReset();

    #12;
    chk("rst_ready", din_ready_o, 0);
    chk("rst_cnt", cnt_o, 0);
    chk("rst_done", done_o, 0);
    checkPoly("rst_poly");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Parse: bytes 01 02 03 00 0D 00 FF FF
    applyStimulus(1, 0, 64'd0, took);
    applyStimulus(0, 1, 64'hFFFF_000D_0003_0201, took);
    applyStimulus(0, 0, 64'd0, took);
    chk("parse_cnt2", cnt_o, 2);
    chk("parse_p0", poly_o[0], 513);
    chk("parse_p1", poly_o[1], 48);
    applyStimulus(0, 0, 64'd0, took);
    chk("parse_p2", poly_o[2], 3328);
    chk("parse_cnt4", cnt_o, 4);

    // Rejection: all-FF word, then 01 0D 10 (3329 rejected, 256 kept)
    applyStimulus(1, 0, 64'd0, took);
    applyStimulus(0, 1, 64'hFFFF_FFFF_FFFF_FFFF, took);
    repeat (4) applyStimulus(0, 0, 64'd0, took);
    chk("reject_ff_cnt", cnt_o, 0);
    applyStimulus(1, 0, 64'd0, took);
    applyStimulus(0, 1, 64'hFFFF_FFFF_FF10_0D01, took);
    applyStimulus(0, 0, 64'd0, took);
    chk("reject_3329_cnt", cnt_o, 1);
    chk("reject_p0", poly_o[0], 256);
    repeat (3) applyStimulus(0, 0, 64'd0, took);
    checkPoly("reject_poly");

    // Boundary at 255 under continuous valid (also measures throughput)
    for (int t = 0; t < 127; t++) begin
      c1 = 12'($urandom_range(0, 3328));
      c2 = 12'($urandom_range(0, 3328));
      bytes.push_back(c1[7:0]);
      bytes.push_back({c2[3:0], c1[11:8]});
      bytes.push_back(c2[11:4]);
    end
    c1 = 12'($urandom_range(0, 3328));
    bytes.push_back(c1[7:0]);
    bytes.push_back({4'h0, c1[11:8]});
    bytes.push_back(8'hFF);
    bytes.push_back(8'h00);
    bytes.push_back(8'h01);
    bytes.push_back(8'h01);
    while ((bytes.size() % 8) != 0) bytes.push_back(8'hFF);
    for (int wi = 0; wi < bytes.size() / 8; wi++) begin
      for (int k = 0; k < 8; k++) w[8*k +: 8] = bytes[8*wi + k];
      words.push_back(w);
    end
    doneRises = 0;
    applyStimulus(1, 0, 64'd0, took);
    idx = 0;
    n   = 0;
    while ((idx < words.size()) && !mDone && (n < 1000)) begin
      if (n == 8) dutAccepts = 0;
      if (n == 32) chk("throughput_3of8", dutAccepts, 9);
      applyStimulus(0, 1, words[idx], took);
      if (took) idx++;
      n++;
    end
    n = 0;
    while (!mDone && (n < 200)) begin
      applyStimulus(0, 0, 64'd0, took);
      n++;
    end
    chk("bnd_done", done_o, 1);
    chk("bnd_cnt", cnt_o, 256);
    chk("bnd_p254", poly_o[254], c1);
    chk("bnd_p255", poly_o[255], 256);
    repeat (4) applyStimulus(0, 1, {$urandom, $urandom}, took);
    chk("bnd_done_once", doneRises, 1);
    checkPoly("bnd_poly");

    // Full random run with valid gaps
    doneRises = 0;
    applyStimulus(1, 0, 64'd0, took);
    w = {$urandom, $urandom};
    n = 0;
    while (!mDone && (n < 3000)) begin
      applyStimulus(0, 1'($urandom_range(0, 1)), w, took);
      if (took) w = {$urandom, $urandom};
      n++;
    end
    chk("full_done", done_o, 1);
    chk("full_cnt", cnt_o, 256);
    repeat (5) applyStimulus(0, 1, {$urandom, $urandom}, took);
    chk("full_done_once", doneRises, 1);
    checkPoly("full_poly");

    // Restart around cnt=100 with valid in the same cycle
    applyStimulus(1, 0, 64'd0, took);
    w = {$urandom, $urandom};
    n = 0;
    while ((mCnt < 100) && (n < 500)) begin
      applyStimulus(0, 1, w, took);
      if (took) w = {$urandom, $urandom};
      n++;
    end
    applyStimulus(1, 1, {$urandom, $urandom}, took);
    chk("restart_cnt0", cnt_o, 0);
    chk("restart_done0", done_o, 0);
    applyStimulus(0, 1, 64'hFFFF_FFFF_FF10_0D01, took);
    applyStimulus(0, 0, 64'd0, took);
    chk("restart_p0", poly_o[0], 256);
    chk("restart_cnt1", cnt_o, 1);
    checkPoly("restart_poly");

    // Asynchronous reset mid-run
    repeat (3) applyStimulus(0, 1, {$urandom, $urandom}, took);
    #2;
    rst_n = 1'b0;
    #1;
    modelReset();
    chk("areset_cnt", cnt_o, 0);
    chk("areset_done", done_o, 0);
    chk("areset_ready", din_ready_o, 0);
    checkPoly("areset_poly");
    start_i     = 1'b0;
    din_valid_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(0, 1, {$urandom, $urandom}, took);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
